apb_mem_slave_wait: RTL and testbench

- Parametrised APB memory-mapped slave; next generation of the team's single-state-machine APB memory block.
- Configurable data width, depth and programmable wait states.
- Registered outputs; address range and alignment checks reported on P_slverr; clean abort on protocol violation.
- Sits behind the APB bridge as a generic scratch RAM / register-file target.

---
 rtl/apb_mem_slave_wait.sv | 115 +++++++++++
 tb/tb_apb_mem_slave_wait.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave_wait.sv
// APB scratch-RAM slave with programmable wait states, range/alignment errors and abort on protocol violation.
// Optional byte-lane write strobes (P_strb) are enabled by defining APB_MEM_PSTRB_EN.
module apb_mem_slave_wait #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    P_clk,
    input  logic                    P_rst,
    input  logic [ADDR_WIDTH-1:0]   P_addr,
    input  logic                    P_selx,
    input  logic                    P_enable,
    input  logic                    P_write,
    input  logic [DATA_WIDTH-1:0]   P_wdata,
`ifdef APB_MEM_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] P_strb,
`endif
    output logic                    P_ready,
    output logic                    P_slverr,
    output logic [DATA_WIDTH-1:0]   P_rdata
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int B = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            cnt;
`ifdef APB_MEM_PSTRB_EN
    logic [NB-1:0]         strb_q;
`endif

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [IDX_W-1:0]      idx_in;
    logic                  err_in;

    assign word_idx = P_addr >> B;
    assign idx_in   = word_idx[IDX_W-1:0];
    assign err_in   = ((P_addr & ADDR_WIDTH'(NB - 1)) != '0) || (word_idx >= ADDR_WIDTH'(DEPTH));

    always_ff @(posedge P_clk or posedge P_rst) begin
        if (P_rst) begin
            state    <= IDLE;
            P_ready  <= 1'b0;
            P_slverr <= 1'b0;
            P_rdata  <= '0;
            cnt      <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
`ifdef APB_MEM_PSTRB_EN
            strb_q   <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
        end else begin
            case (state)
                IDLE: begin
                    // P_selx & P_enable without a preceding setup phase is ignored here
                    if (P_selx && !P_enable) begin
                        idx_q   <= idx_in;
                        write_q <= P_write;
                        err_q   <= err_in;
                        wdata_q <= P_wdata;
`ifdef APB_MEM_PSTRB_EN
                        strb_q  <= P_strb;
`endif
                        cnt     <= 4'(WAIT_CYCLES);
                        state   <= ACCESS;
                        if (WAIT_CYCLES == 0) begin
                            P_ready  <= 1'b1;
                            P_slverr <= err_in;
                            if (!P_write) P_rdata <= err_in ? '0 : mem[idx_in];
                        end
                    end
                end
                ACCESS: begin
                    if (!P_selx || !P_enable) begin
                        P_ready  <= 1'b0;
                        P_slverr <= 1'b0;
                        state    <= IDLE;
                    end else if (P_ready) begin
                        if (write_q && !err_q) begin
`ifdef APB_MEM_PSTRB_EN
                            for (int b = 0; b < NB; b++)
                                if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
`else
                            mem[idx_q] <= wdata_q;
`endif
                        end
                        P_ready  <= 1'b0;
                        P_slverr <= 1'b0;
                        state    <= IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            P_ready  <= 1'b1;
                            P_slverr <= err_q;
                            if (!write_q) P_rdata <= err_q ? '0 : mem[idx_q];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_mem_slave_wait.sv
// Bench for apb_mem_slave_wait: three instances (0, 2 and 3 wait states) checked against a transaction-level model.
module tb_apb_mem_slave_wait;
    localparam logic [31:0] RV = 32'hC0FF_EE00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        selx [3];
    logic        en [3];
    logic        wr [3];
    logic        ready [3];
    logic        slverr [3];
    logic [3:0]  strb [3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    apb_mem_slave_wait #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_CYCLES(0), .RESET_VAL(RV)) u_w0 (
        .P_clk(clk), .P_rst(rst), .P_addr(addr[0]), .P_selx(selx[0]), .P_enable(en[0]),
        .P_write(wr[0]), .P_wdata(wdata[0]),
`ifdef APB_MEM_PSTRB_EN
        .P_strb(strb[0]),
`endif
        .P_ready(ready[0]), .P_slverr(slverr[0]), .P_rdata(rdata[0]));

    apb_mem_slave_wait #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_CYCLES(2), .RESET_VAL(RV)) u_w2 (
        .P_clk(clk), .P_rst(rst), .P_addr(addr[1]), .P_selx(selx[1]), .P_enable(en[1]),
        .P_write(wr[1]), .P_wdata(wdata[1]),
`ifdef APB_MEM_PSTRB_EN
        .P_strb(strb[1]),
`endif
        .P_ready(ready[1]), .P_slverr(slverr[1]), .P_rdata(rdata[1]));

    apb_mem_slave_wait #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_CYCLES(3), .RESET_VAL(RV)) u_w3 (
        .P_clk(clk), .P_rst(rst), .P_addr(addr[2]), .P_selx(selx[2]), .P_enable(en[2]),
        .P_write(wr[2]), .P_wdata(wdata[2]),
`ifdef APB_MEM_PSTRB_EN
        .P_strb(strb[2]),
`endif
        .P_ready(ready[2]), .P_slverr(slverr[2]), .P_rdata(rdata[2]));

    function automatic int waits(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    // Model: one pending transfer per slave, timed from the setup edge.
    bit          act [3];
    int          es [3];
    logic [31:0] ma [3];
    logic [31:0] md [3];
    bit          mw [3];
    bit          merr [3];
    logic [3:0]  ms [3];
    logic [31:0] mm [3][32];
    bit          exp_rdy [3];
    bit          exp_err [3];
    logic [31:0] exp_rd [3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                act[d] = 0; exp_rdy[d] = 0; exp_err[d] = 0; exp_rd[d] = '0;
                for (int i = 0; i < 32; i++) mm[d][i] = RV;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                bit present;
                present = 0;
                if (!act[d]) begin
                    exp_rdy[d] = 0; exp_err[d] = 0;
                    if (selx[d] && !en[d]) begin
                        act[d] = 1; es[d] = cyc; ma[d] = addr[d]; md[d] = wdata[d];
                        mw[d] = wr[d]; ms[d] = strb[d];
                        merr[d] = (addr[d] % 4 != 0) || (addr[d] / 4 >= 32);
                        if (waits(d) == 0) present = 1;
                    end
                end else if (!(selx[d] && en[d])) begin
                    act[d] = 0; exp_rdy[d] = 0; exp_err[d] = 0;
                end else if (cyc == es[d] + waits(d) + 1) begin
                    if (mw[d] && !merr[d]) begin
                        logic [3:0] mask;
`ifdef APB_MEM_PSTRB_EN
                        mask = ms[d];
`else
                        mask = 4'hF;
`endif
                        for (int b = 0; b < 4; b++)
                            if (mask[b]) mm[d][ma[d] / 4][8*b +: 8] = md[d][8*b +: 8];
                    end
                    act[d] = 0; exp_rdy[d] = 0; exp_err[d] = 0;
                end else if (cyc == es[d] + waits(d)) begin
                    present = 1;
                end
                if (present) begin
                    exp_rdy[d] = 1;
                    exp_err[d] = merr[d];
                    if (!mw[d]) exp_rd[d] = merr[d] ? 32'h0 : mm[d][ma[d] / 4];
                end
            end
        end
    end

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", nm, d, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                chk("ready", d, 32'(ready[d]), 32'(exp_rdy[d]));
                chk("slverr", d, 32'(slverr[d]), 32'(exp_err[d]));
                chk("rdata", d, rdata[d], exp_rd[d]);
            end
        end
    end

    task automatic xfer(input int d, input logic [31:0] a, input bit w, input logic [31:0] dat,
                        input logic [3:0] sb, output logic [31:0] rd, output logic er,
                        output int lat, output int t_rdy);
        selx[d] = 1; en[d] = 0; addr[d] = a; wr[d] = w; wdata[d] = dat; strb[d] = sb;
        @(negedge clk);
        en[d] = 1; addr[d] = ~a; wdata[d] = ~dat;
        lat = 1;
        while (!ready[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!ready[d]) begin
            failures++;
            $display("FAIL ready_timeout dut%0d addr=%h: P_ready not seen within %0d cycles", d, a, lat);
        end
        rd = rdata[d]; er = slverr[d]; t_rdy = cyc;
        @(negedge clk);
        selx[d] = 0; en[d] = 0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, t1, t2;

    initial begin
        for (int d = 0; d < 3; d++) begin
            selx[d] = 0; en[d] = 0; wr[d] = 0; addr[d] = '0; wdata[d] = '0; strb[d] = 4'hF;
        end
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);

        // Reset contents, zero-wait latency
        xfer(0, 32'h0, 0, 32'h0, 4'hF, rd, er, lat, t1);
        chk("rst_read_data", 0, rd, RV);
        chk("rst_read_err", 0, 32'(er), 32'h0);
        chk("w0_latency", 0, 32'(lat), 32'd1);

        // Back-to-back write then read
        xfer(0, 32'h14, 1, 32'hDEAD_BEEF, 4'hF, rd, er, lat, t1);
        xfer(0, 32'h14, 0, 32'h0, 4'hF, rd, er, lat, t2);
        chk("b2b_read_data", 0, rd, 32'hDEAD_BEEF);
        chk("b2b_ready_gap", 0, 32'(t2 - t1), 32'd2);

        // Three wait states
        xfer(2, 32'h8, 1, 32'h1357_2468, 4'hF, rd, er, lat, t1);
        chk("w3_write_latency", 2, 32'(lat), 32'd4);
        xfer(2, 32'h8, 0, 32'h0, 4'hF, rd, er, lat, t1);
        chk("w3_read_latency", 2, 32'(lat), 32'd4);
        chk("w3_read_data", 2, rd, 32'h1357_2468);
        chk("w3_read_err", 2, 32'(er), 32'h0);

        // Out-of-range and misaligned accesses
        xfer(0, 32'h80, 1, 32'h1234_5678, 4'hF, rd, er, lat, t1);
        chk("range_write_err", 0, 32'(er), 32'h1);
        xfer(0, 32'h6, 1, 32'h1234_5678, 4'hF, rd, er, lat, t1);
        chk("misalign_write_err", 0, 32'(er), 32'h1);
        xfer(0, 32'h0, 0, 32'h0, 4'hF, rd, er, lat, t1);
        chk("after_err_read0", 0, rd, RV);
        xfer(0, 32'h4, 0, 32'h0, 4'hF, rd, er, lat, t1);
        chk("after_err_read4", 0, rd, RV);
        xfer(0, 32'h80, 0, 32'h0, 4'hF, rd, er, lat, t1);
        chk("range_read_err", 0, 32'(er), 32'h1);
        chk("range_read_data", 0, rd, 32'h0);

        // Abort by dropping P_selx during the wait
        xfer(1, 32'h10, 1, 32'h0F0F_0F0F, 4'hF, rd, er, lat, t1);
        chk("w2_latency", 1, 32'(lat), 32'd3);
        selx[1] = 1; en[1] = 0; addr[1] = 32'h10; wr[1] = 1; wdata[1] = 32'hA5A5_A5A5;
        @(negedge clk); en[1] = 1;
        @(negedge clk); selx[1] = 0; en[1] = 0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_ready", 1, 32'(ready[1]), 32'h0);
        end
        xfer(1, 32'h10, 0, 32'h0, 4'hF, rd, er, lat, t1);
        chk("abort_mem_kept", 1, rd, 32'h0F0F_0F0F);

        // Reset pulsed mid-wait
        selx[1] = 1; en[1] = 0; addr[1] = 32'h10; wr[1] = 1; wdata[1] = 32'hA5A5_A5A5;
        @(negedge clk); en[1] = 1;
        #2 rst = 1;
        #2 rst = 0;
        chk("midrst_ready", 1, 32'(ready[1]), 32'h0);
        chk("midrst_rdata", 1, rdata[1], 32'h0);
        @(negedge clk); selx[1] = 0; en[1] = 0;
        @(negedge clk);
        xfer(1, 32'h10, 0, 32'h0, 4'hF, rd, er, lat, t1);
        chk("midrst_mem_reset", 1, rd, RV);

        // Access strobe without setup is ignored
        selx[0] = 1; en[0] = 1; addr[0] = 32'h0; wr[0] = 0;
        repeat (3) begin
            @(negedge clk);
            chk("violation_no_ready", 0, 32'(ready[0]), 32'h0);
        end
        selx[0] = 0; en[0] = 0;
        @(negedge clk);

`ifdef APB_MEM_PSTRB_EN
        xfer(0, 32'h8, 1, 32'h1122_3344, 4'hF, rd, er, lat, t1);
        xfer(0, 32'h8, 1, 32'hAABB_CCDD, 4'b0101, rd, er, lat, t1);
        xfer(0, 32'h8, 0, 32'h0, 4'hF, rd, er, lat, t1);
        chk("strb_merge", 0, rd, 32'h11BB_33DD);
        xfer(0, 32'h8, 1, 32'hFFFF_FFFF, 4'b0000, rd, er, lat, t1);
        chk("strb_zero_err", 0, 32'(er), 32'h0);
        xfer(0, 32'h8, 0, 32'h0, 4'hF, rd, er, lat, t1);
        chk("strb_zero_kept", 0, rd, 32'h11BB_33DD);
`endif

        // Sweep of writes then reads on every slave, including the top word
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                logic [31:0] a;
                a = (i == 3) ? 32'h7C : 32'(i * 8 + 4);
                xfer(d, a, 1, 32'h1000_0000 * d + 32'h0101_0101 * i + 32'h77, 4'hF, rd, er, lat, t1);
                chk("sweep_write_err", d, 32'(er), 32'h0);
            end
            for (int i = 0; i < 4; i++) begin
                logic [31:0] a;
                a = (i == 3) ? 32'h7C : 32'(i * 8 + 4);
                xfer(d, a, 0, 32'h0, 4'hF, rd, er, lat, t1);
                chk("sweep_read_data", d, rd, 32'h1000_0000 * d + 32'h0101_0101 * i + 32'h77);
                chk("sweep_latency", d, 32'(lat), 32'(waits(d) + 1));
            end
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
